// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath width, LEGv8 condition-code encodings
// and the architectural NZVC flag layout.
package cpu_pkg;

    localparam int WIDTH_DEFAULT = 64;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_HS = 4'b0010,
        COND_LO = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational LEGv8 B.cond evaluator: decides whether a condition code holds
// for a given set of NZVC flags.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic       flag_n,
    input  logic       flag_z,
    input  logic       flag_v,
    input  logic       flag_c,
    output logic       cond_true
);

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_EQ: cond_true = flag_z;
            COND_NE: cond_true = ~flag_z;
            COND_HS: cond_true = flag_c;
            COND_LO: cond_true = ~flag_c;
            COND_MI: cond_true = flag_n;
            COND_PL: cond_true = ~flag_n;
            COND_VS: cond_true = flag_v;
            COND_VC: cond_true = ~flag_v;
            COND_HI: cond_true = flag_c & ~flag_z;
            COND_LS: cond_true = ~(flag_c & ~flag_z);
            COND_GE: cond_true = (flag_n == flag_v);
            COND_LT: cond_true = (flag_n != flag_v);
            COND_GT: cond_true = ~flag_z & (flag_n == flag_v);
            COND_LE: cond_true = ~(~flag_z & (flag_n == flag_v));
            default: cond_true = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_flag_stage.sv
// Execute-to-memory boundary: registers the ALU result, owns the NZVC flag
// register and resolves B.cond / CBZ / CBNZ branch decisions.
module ex_flag_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inValid,
    input  logic             stall,
    input  logic             flush,
    input  logic [WIDTH-1:0] aluOut,
    input  logic             negative,
    input  logic             zero,
    input  logic             overflow,
    input  logic             carryOut,
    input  logic             setFlags,
    input  logic             isBcond,
    input  logic             isCbz,
    input  logic             isCbnz,
    input  logic [3:0]       cond,
    output logic             outValid,
    output logic [WIDTH-1:0] resultQ,
    output logic             takeBranch,
    output logic             flagN,
    output logic             flagZ,
    output logic             flagV,
    output logic             flagC
);

    logic             accept;
    logic             cond_true;
    logic             decision;

    logic             out_valid_q, out_valid_d;
    logic             take_branch_q, take_branch_d;
    logic [WIDTH-1:0] result_q, result_d;
    flags_t           flags_q, flags_d;

    assign accept = inValid & ~stall & ~flush;

    // B.cond reads the flag register before this instruction's own update.
    cond_eval u_cond_eval (
        .cond      (cond),
        .flag_n    (flags_q.n),
        .flag_z    (flags_q.z),
        .flag_v    (flags_q.v),
        .flag_c    (flags_q.c),
        .cond_true (cond_true)
    );

    always_comb begin
        decision = 1'b0;
        if (isBcond) begin
            decision = cond_true;
        end else if (isCbz) begin
            decision = zero;
        end else if (isCbnz) begin
            decision = ~zero;
        end
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        take_branch_d = take_branch_q;
        result_d      = result_q;
        if (flush) begin
            out_valid_d   = 1'b0;
            take_branch_d = 1'b0;
        end else if (!stall) begin
            out_valid_d   = accept;
            take_branch_d = accept & decision;
            if (accept) begin
                result_d = aluOut;
            end
        end
    end

    always_comb begin
        flags_d = flags_q;
        if (accept && setFlags) begin
            flags_d = '{n: negative, z: zero, v: overflow, c: carryOut};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            take_branch_q <= 1'b0;
            result_q      <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            take_branch_q <= take_branch_d;
            result_q      <= result_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign outValid   = out_valid_q;
    assign takeBranch = take_branch_q;
    assign resultQ    = result_q;
    assign flagN      = flags_q.n;
    assign flagZ      = flags_q.z;
    assign flagV      = flags_q.v;
    assign flagC      = flags_q.c;

endmodule

// File: tb/tb_ex_flag_stage.sv
// Directed and randomized checks of ex_flag_stage against a behavioural model
// of the execute/flag stage.
module tb_ex_flag_stage;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset, inValid, stall, flush;
    logic [W-1:0] aluOut;
    logic         negative, zero, overflow, carryOut;
    logic         setFlags, isBcond, isCbz, isCbnz;
    logic [3:0]   cond;
    logic         outValid, takeBranch;
    logic [W-1:0] resultQ;
    logic         flagN, flagZ, flagV, flagC;

    int checks = 0;
    int errors = 0;

    // Model state
    logic         m_valid;
    logic         m_tb;
    logic [W-1:0] m_res;
    logic [3:0]   m_flags;   // {N,Z,V,C}

    always #5 clk = ~clk;

    ex_flag_stage #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .inValid    (inValid),
        .stall      (stall),
        .flush      (flush),
        .aluOut     (aluOut),
        .negative   (negative),
        .zero       (zero),
        .overflow   (overflow),
        .carryOut   (carryOut),
        .setFlags   (setFlags),
        .isBcond    (isBcond),
        .isCbz      (isCbz),
        .isCbnz     (isCbnz),
        .cond       (cond),
        .outValid   (outValid),
        .resultQ    (resultQ),
        .takeBranch (takeBranch),
        .flagN      (flagN),
        .flagZ      (flagZ),
        .flagV      (flagV),
        .flagC      (flagC)
    );

    // ARM-style evaluation: cond[3:1] selects a base test, cond[0] inverts it
    // (except for the always-true pair).
    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, v, cc, b;
        n = f[3]; z = f[2]; v = f[1]; cc = f[0];
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cc;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cc && !z;
            3'd5: b = (n == v);
            3'd6: b = !z && (n == v);
            default: b = 1'b1;
        endcase
        return (c[3:1] != 3'd7 && c[0]) ? !b : b;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, advance the model, compare after the edge.
    task automatic step(input string tag, input logic rst, input logic v, input logic s,
                        input logic f, input logic sf, input logic bc, input logic cz,
                        input logic cnz, input logic [3:0] c, input logic [63:0] a,
                        input logic [3:0] fl);
        logic br;
        @(negedge clk);
        reset = rst; inValid = v; stall = s; flush = f; setFlags = sf;
        isBcond = bc; isCbz = cz; isCbnz = cnz; cond = c; aluOut = a;
        {negative, zero, overflow, carryOut} = fl;
        br = bc ? cond_model(c, m_flags) : cz ? fl[2] : cnz ? !fl[2] : 1'b0;
        if (rst) begin
            m_valid = 0; m_tb = 0; m_res = '0; m_flags = '0;
        end else if (f) begin
            m_valid = 0; m_tb = 0;
        end else if (!s) begin
            m_valid = v;
            m_tb    = v && br;
            if (v) begin
                m_res = a;
                if (sf) m_flags = fl;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, ".outValid"}, 64'(outValid), 64'(m_valid));
        chk({tag, ".takeBranch"}, 64'(takeBranch), 64'(m_tb));
        chk({tag, ".resultQ"}, resultQ, m_res);
        chk({tag, ".flags"}, 64'({flagN, flagZ, flagV, flagC}), 64'(m_flags));
    endtask

    initial begin
        logic [3:0] pre_flags;
        logic r, v, s, f, sf;
        int kind;
        m_valid = 0; m_tb = 0; m_res = '0; m_flags = '0;
        reset = 1; inValid = 0; stall = 0; flush = 0; setFlags = 0;
        isBcond = 0; isCbz = 0; isCbnz = 0; cond = 0; aluOut = '0;
        negative = 0; zero = 0; overflow = 0; carryOut = 0;

        step("reset", 1, 1, 0, 0, 1, 0, 0, 0, 4'h0, 64'hFFFF, 4'b1111);
        chk("reset.flags_zero", 64'({flagN, flagZ, flagV, flagC}), 64'h0);

        // SUBS 5-5: Z=1, C=1
        step("subs55", 0, 1, 0, 0, 1, 0, 0, 0, 4'h0, 64'h0, 4'b0101);
        chk("subs55.flags_lit", 64'({flagN, flagZ, flagV, flagC}), 64'h5);
        chk("subs55.valid_lit", 64'(outValid), 64'h1);

        // B.EQ / B.NE see the freshly written flags; non-flag op leaves them alone
        step("beq", 0, 1, 0, 0, 0, 1, 0, 0, 4'b0000, 64'h10, 4'b1010);
        chk("beq.taken_lit", 64'(takeBranch), 64'h1);
        step("bne", 0, 1, 0, 0, 0, 1, 0, 0, 4'b0001, 64'h20, 4'b1010);
        chk("bne.taken_lit", 64'(takeBranch), 64'h0);
        chk("bne.flags_lit", 64'({flagN, flagZ, flagV, flagC}), 64'h5);

        // SUBS with N=1, V=1 then GE / LT
        step("subs_nv", 0, 1, 0, 0, 1, 0, 0, 0, 4'h0, 64'hFFFF_FFFF_FFFF_FFF0, 4'b1010);
        step("bge", 0, 1, 0, 0, 0, 1, 0, 0, 4'b1010, 64'h30, 4'b0000);
        chk("bge.taken_lit", 64'(takeBranch), 64'h1);
        step("blt", 0, 1, 0, 0, 0, 1, 0, 0, 4'b1011, 64'h40, 4'b0000);
        chk("blt.taken_lit", 64'(takeBranch), 64'h0);

        // CBZ / CBNZ use the zero input, not the flag register
        step("cbz", 0, 1, 0, 0, 0, 0, 1, 0, 4'h0, 64'h0, 4'b0100);
        chk("cbz.taken_lit", 64'(takeBranch), 64'h1);
        step("cbnz", 0, 1, 0, 0, 0, 0, 0, 1, 4'h0, 64'h0, 4'b0100);
        chk("cbnz.taken_lit", 64'(takeBranch), 64'h0);
        chk("cbnz.flags_lit", 64'({flagN, flagZ, flagV, flagC}), 64'hA);

        // ADDS stalled three cycles, then flushed
        pre_flags = {flagN, flagZ, flagV, flagC};
        for (int i = 0; i < 3; i++)
            step("adds_stall", 0, 1, 1, 0, 1, 1, 0, 0, 4'b1110, 64'h77, 4'b0001);
        chk("adds_stall.valid_held", 64'(outValid), 64'h1);
        step("adds_flush", 0, 1, 1, 1, 1, 1, 0, 0, 4'b1110, 64'h77, 4'b0001);
        chk("adds_flush.valid_lit", 64'(outValid), 64'h0);
        chk("adds_flush.flags_pre", 64'({flagN, flagZ, flagV, flagC}), 64'(pre_flags));

        // Reset while stalled with a valid result held
        step("fill", 0, 1, 0, 0, 1, 0, 0, 1, 4'h0, 64'hDEAD, 4'b1011);
        step("rst_stall", 1, 1, 1, 0, 1, 0, 0, 0, 4'h0, 64'hBEEF, 4'b1111);
        chk("rst_stall.result_lit", resultQ, 64'h0);
        step("add1234", 0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 64'h1234, 4'b1111);
        chk("add1234.result_lit", resultQ, 64'h1234);
        chk("add1234.flags_lit", 64'({flagN, flagZ, flagV, flagC}), 64'h0);

        for (int i = 0; i < 400; i++) begin
            r    = ($urandom_range(0, 40) == 0);
            v    = ($urandom_range(0, 3) != 0);
            s    = ($urandom_range(0, 3) == 0);
            f    = ($urandom_range(0, 5) == 0);
            sf   = $urandom_range(0, 1);
            kind = $urandom_range(0, 3);
            step("rand", r, v, s, f, sf, kind == 1, kind == 2, kind == 3,
                 4'($urandom_range(0, 15)), {$urandom, $urandom}, 4'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_flag_stage.md
EX_FLAG_STAGE -- requirements
Module: ex_flag_stage

Interface
REQ-001 Parameter WIDTH, default 64, datapath width of the ALU result carried through the stage.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 inValid  input  1  an instruction is presented by the execute ALU this cycle.
REQ-005 stall  input  1  hold all stage state; accept nothing.
REQ-006 flush  input  1  squash the presented instruction.
REQ-007 aluOut  input  WIDTH  ALU result.
REQ-008 negative, zero, overflow, carryOut  input  1 each  ALU flags for aluOut.
REQ-009 setFlags  input  1  instruction is a flag-setting op (ADDS/SUBS/ANDS).
REQ-010 isBcond, isCbz, isCbnz  input  1 each  branch kind; at most one set.
REQ-011 cond  input  4  LEGv8 condition code for B.cond.
REQ-012 outValid  output  1  registered result valid for the memory stage.
REQ-013 resultQ  output  WIDTH  registered aluOut.
REQ-014 takeBranch  output  1  registered branch decision for the accepted instruction.
REQ-015 flagN, flagZ, flagV, flagC  output  1 each  architectural condition-flag register.

Function
REQ-016 Accept = inValid & ~stall & ~flush; latency of one cycle from accept to outValid=1.
REQ-017 On accept: resultQ <= aluOut, outValid <= 1, takeBranch <= decision of REQ-019/020.
REQ-018 On accept with setFlags=1: {flagN,flagZ,flagV,flagC} <= {negative,zero,overflow,carryOut}; otherwise flags hold.
REQ-019 B.cond decision uses current flag register (pre-update): 0000 EQ Z; 0001 NE ~Z; 0010 HS C; 0011 LO ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V; 1000 HI C&~Z; 1001 LS ~(C&~Z); 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE ~(~Z&(N==V)); 1110 and 1111 always.
REQ-020 CBZ decision = zero input; CBNZ decision = ~zero input; no branch kind set -> takeBranch=0.
REQ-021 Flag-setting op followed next cycle by B.cond: B.cond sees flags written by the prior op (register already updated).
REQ-022 stall=1 (flush=0): resultQ, outValid, takeBranch, flags all hold.
REQ-023 flush=1: outValid <= 0, takeBranch <= 0, flags hold, regardless of stall or inValid.
REQ-024 inValid=0, stall=0, flush=0: outValid <= 0, takeBranch <= 0, resultQ and flags hold.
REQ-025 Flags are never modified by an unaccepted instruction.

Reset
REQ-026 reset=1 at a rising edge: outValid=0, takeBranch=0, resultQ=0, all four flags=0, overriding stall, flush and inValid.
REQ-027 reset mid-stall discards held instruction; first accept after deassertion behaves per REQ-017.

Structure
REQ-028 Condition-code 4-bit encodings (EQ..AL) and WIDTH default constant belong in shared package cpu_pkg.
REQ-029 One sub-module cond_eval: combinational, inputs cond and four flags, output condition-true.
REQ-030 Flag register and pipeline register are separate always blocks sharing the accept term.

Verification
REQ-031 Reset, then SUBS 5-5 (zero=1, carryOut=1, setFlags=1, inValid=1) -> next cycle flagZ=1, flagC=1, flagN=0, flagV=0, outValid=1, resultQ=0.
REQ-032 After REQ-031, B.cond cond=0000 next cycle -> takeBranch=1; same with cond=0001 -> takeBranch=0; flags unchanged.
REQ-033 SUBS with negative=1, overflow=1 then B.cond GE (1010) -> takeBranch=1; then LT (1011) -> takeBranch=0.
REQ-034 CBZ with zero=1, flags N=1 -> takeBranch=1; CBNZ with zero=1 -> takeBranch=0; flags untouched.
REQ-035 ADDS presented with stall=1 for 3 cycles then flush=1 -> outputs held during stall, then outValid=0, flags equal pre-ADDS values.
REQ-036 reset asserted while stall=1 and outValid=1 -> next cycle all outputs 0; then accept ADD (setFlags=0, aluOut=0x1234) -> resultQ=0x1234, flags remain 0.
